// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/funct constants, instruction classes and pipeline stage record
package cpu_pkg;

    localparam logic [5:0] OP_LW    = 6'b001110;
    localparam logic [5:0] OP_SW    = 6'b001111;
    localparam logic [5:0] OP_RTYPE = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b110010;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU   = 3'd1,
        CLS_MUL   = 3'd2,
        CLS_LOAD  = 3'd3,
        CLS_STORE = 3'd4
    } cls_e;

    // rd is forced to zero for anything that does not write, so rd != 0 means "pending write"
    typedef struct packed {
        logic       valid;
        cls_e       cls;
        logic [4:0] rd;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '{valid: 1'b0, cls: CLS_NOP, rd: 5'd0};

    function automatic logic stage_hit(input stage_t s, input logic src_v, input logic [4:0] src);
        return src_v && s.valid && (s.rd == src);
    endfunction

endpackage

// File: rtl/issue_sequencer_if.sv
// rtl/issue_sequencer_if.sv - decode-side handshake and EX/MEM/WB control bundle
interface issue_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        issue;
    logic        stall;
    logic        ex_mul_start;
    logic        ex_busy;
    logic        mem_re;
    logic        mem_we;
    logic        wb_we;
    logic [4:0]  wb_rd;

    modport slave (
        input  instr_valid, instr,
        output issue, stall, ex_mul_start, ex_busy, mem_re, mem_we, wb_we, wb_rd
    );

    modport master (
        output instr_valid, instr,
        input  issue, stall, ex_mul_start, ex_busy, mem_re, mem_we, wb_we, wb_rd
    );
endinterface

// File: rtl/issue_decode.sv
// rtl/issue_decode.sv - combinational class, source-valid and destination extraction
import cpu_pkg::*;

module issue_decode (
    input  logic [31:0] instr,
    output cls_e        cls,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        rs_v,
    output logic        rt_v,
    output logic [4:0]  rd
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       rs_used;
    logic       rt_used;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    // r0 as a source never creates a dependency
    assign rs_v   = rs_used && (rs != 5'd0);
    assign rt_v   = rt_used && (rt != 5'd0);

    always_comb begin
        cls     = CLS_NOP;
        rs_used = 1'b0;
        rt_used = 1'b0;
        rd      = 5'd0;
        case (opcode)
            OP_LW: begin
                cls     = CLS_LOAD;
                rs_used = 1'b1;
                rd      = instr[20:16];
            end
            OP_SW: begin
                cls     = CLS_STORE;
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR: begin
                        cls     = CLS_ALU;
                        rs_used = 1'b1;
                        rt_used = 1'b1;
                        rd      = instr[15:11];
                    end
                    FN_MUL: begin
                        cls     = CLS_MUL;
                        rs_used = 1'b1;
                        rt_used = 1'b1;
                        rd      = instr[15:11];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/issue_sequencer.sv
// rtl/issue_sequencer.sv - in-order issue with RAW stall and MUL hold; ISSUE_WB_BYPASS_EN drops WB from the hazard check
import cpu_pkg::*;

module issue_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    issue_sequencer_if.slave  bus
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

    stage_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    cls_e       dec_cls;
    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic       dec_rs_v, dec_rt_v;

    issue_decode u_decode (
        .instr (bus.instr),
        .cls   (dec_cls),
        .rs    (dec_rs),
        .rt    (dec_rt),
        .rs_v  (dec_rs_v),
        .rt_v  (dec_rt_v),
        .rd    (dec_rd)
    );

    logic ex_hold, hazard, wb_hazard, stall, issue;

`ifdef ISSUE_WB_BYPASS_EN
    // register file writes before it reads, so the WB producer is already visible
    assign wb_hazard = 1'b0;
`else
    assign wb_hazard = stage_hit(wb_q, dec_rs_v, dec_rs) || stage_hit(wb_q, dec_rt_v, dec_rt);
`endif

    assign hazard = stage_hit(ex_q,  dec_rs_v, dec_rs) || stage_hit(ex_q,  dec_rt_v, dec_rt) ||
                    stage_hit(mem_q, dec_rs_v, dec_rs) || stage_hit(mem_q, dec_rt_v, dec_rt) ||
                    wb_hazard;

    assign ex_hold = ex_q.valid && (ex_q.cls == CLS_MUL) && (cnt_q != '0);
    assign stall   = bus.instr_valid && (hazard || ex_hold);
    assign issue   = bus.instr_valid && !stall;

    always_comb begin
        ex_d  = ex_q;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (ex_hold) begin
            cnt_d = cnt_q - 1'b1;
            mem_d = STAGE_BUBBLE;
        end else if (issue) begin
            ex_d  = '{valid: 1'b1, cls: dec_cls, rd: dec_rd};
            cnt_d = (dec_cls == CLS_MUL) ? MUL_LOAD : '0;
        end else begin
            ex_d  = STAGE_BUBBLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.issue        = issue;
    assign bus.ex_busy      = ex_hold;
    // counter only equals its load value in the first EX cycle of a MUL
    assign bus.ex_mul_start = ex_q.valid && (ex_q.cls == CLS_MUL) && (cnt_q == MUL_LOAD);
    assign bus.mem_re       = mem_q.valid && (mem_q.cls == CLS_LOAD);
    assign bus.mem_we       = mem_q.valid && (mem_q.cls == CLS_STORE);
    assign bus.wb_we        = wb_q.valid && (wb_q.rd != 5'd0);
    assign bus.wb_rd        = bus.wb_we ? wb_q.rd : 5'd0;
endmodule
